// File: rtl/beeper_pkg.sv
// rtl/beeper_pkg.sv - shared types and widths for the cadenced piezo beeper
package beeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TONE,
    GAP,
    HOLD
  } beeper_state_t;

  localparam int CNT_W   = 32;
  localparam int BURST_W = 8;

endpackage

// File: rtl/beeper_div.sv
// rtl/beeper_div.sv - loadable half-period down-counter producing the tone toggle tick
module beeper_div #(
  parameter int HW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [HW-1:0] half,
  output logic          tick
);

  logic [HW-1:0] cnt_q, cnt_d;

  // Loading with half-1 makes tick fire on the last cycle of each half-period.
  always_comb begin
    cnt_d = cnt_q - HW'(1);
    if (load || cnt_q == '0) begin
      cnt_d = half - HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/sound_beeper.sv
// rtl/sound_beeper.sv - burst-cadenced square-wave alert driver for the entry-alarm piezo
module sound_beeper
  import beeper_pkg::*;
#(
  parameter int HALF_BASE  = 25000,
  parameter int HALF_STEP  = 100,
  parameter int ON_CYC     = 5000000,
  parameter int OFF_CYC    = 5000000,
  parameter int MAX_BURSTS = 0,
  parameter int HW         = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         amount,
  input  logic               soundenable,
  output logic               speaker,
  output logic               active,
  output logic               done,
  output logic [BURST_W-1:0] bursts
);

  beeper_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] bursts_q, bursts_d;
  logic [7:0]         amt_q, amt_d;
  logic               spk_q, spk_d;
  logic               active_q, done_q;
  logic               load;
  logic               tick;
  logic [7:0]         amt_src;
  logic [HW-1:0]      half;

  // On a burst start the divider must see the pitch being captured this edge.
  assign amt_src = load ? amount : amt_q;
  assign half    = HW'(HALF_BASE) + HW'(HALF_STEP) * HW'(amt_src);

  beeper_div #(.HW(HW)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .half  (half),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bursts_d = bursts_q;
    amt_d    = amt_q;
    spk_d    = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (soundenable) begin
          state_d  = TONE;
          cnt_d    = '0;
          bursts_d = BURST_W'(1);
          amt_d    = amount;
          spk_d    = 1'b1;
          load     = 1'b1;
        end
      end
      TONE: begin
        if (!soundenable) begin
          state_d  = IDLE;
          cnt_d    = '0;
          bursts_d = '0;
        end else if (cnt_q == CNT_W'(ON_CYC - 1)) begin
          cnt_d   = '0;
          state_d = (MAX_BURSTS != 0 && bursts_q == BURST_W'(MAX_BURSTS)) ? HOLD : GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          spk_d = tick ? ~spk_q : spk_q;
        end
      end
      GAP: begin
        if (!soundenable) begin
          state_d  = IDLE;
          cnt_d    = '0;
          bursts_d = '0;
        end else if (cnt_q == CNT_W'(OFF_CYC - 1)) begin
          state_d  = TONE;
          cnt_d    = '0;
          bursts_d = (bursts_q == '1) ? bursts_q : bursts_q + BURST_W'(1);
          amt_d    = amount;
          spk_d    = 1'b1;
          load     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!soundenable) begin
          state_d  = IDLE;
          cnt_d    = '0;
          bursts_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        bursts_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bursts_q <= '0;
      amt_q    <= '0;
      spk_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bursts_q <= bursts_d;
      amt_q    <= amt_d;
      spk_q    <= spk_d;
      active_q <= (state_d == TONE) || (state_d == GAP);
      done_q   <= (state_d == HOLD);
    end
  end

  assign speaker = spk_q;
  assign active  = active_q;
  assign done    = done_q;
  assign bursts  = bursts_q;

endmodule

// File: tb/tb_sound_beeper.sv
// tb/tb_sound_beeper.sv - directed and randomized checks of sound_beeper against a timeline model
module tb_sound_beeper;

  localparam int HB  = 4;
  localparam int HS  = 2;
  localparam int ON  = 20;
  localparam int OFF = 10;
  localparam int MB  = 2;

  localparam int P_IDLE = 0;
  localparam int P_TONE = 1;
  localparam int P_GAP  = 2;
  localparam int P_HOLD = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       soundenable;
  logic [7:0] amount;
  logic       speaker;
  logic       active;
  logic       done;
  logic [7:0] bursts;

  int tests = 0;
  int fails = 0;

  int m_phase;
  int m_t;
  int m_h;
  int m_bursts;

  always #5 clk = ~clk;

  sound_beeper #(
    .HALF_BASE  (HB),
    .HALF_STEP  (HS),
    .ON_CYC     (ON),
    .OFF_CYC    (OFF),
    .MAX_BURSTS (MB),
    .HW         (24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .amount      (amount),
    .soundenable (soundenable),
    .speaker     (speaker),
    .active      (active),
    .done        (done),
    .bursts      (bursts)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_burst(input int nb);
    m_phase  = P_TONE;
    m_t      = 0;
    m_h      = HB + int'(amount) * HS;
    m_bursts = (nb > 255) ? 255 : nb;
  endtask

  task automatic go_idle();
    m_phase  = P_IDLE;
    m_t      = 0;
    m_bursts = 0;
  endtask

  // Reference: elapsed time inside the current phase decides every output.
  task automatic model_edge();
    if (reset) begin
      go_idle();
    end else begin
      case (m_phase)
        P_IDLE: if (soundenable) start_burst(1);
        P_TONE: begin
          if (!soundenable) go_idle();
          else if (m_t + 1 == ON) begin
            m_phase = (MB != 0 && m_bursts == MB) ? P_HOLD : P_GAP;
            m_t = 0;
          end else m_t++;
        end
        P_GAP: begin
          if (!soundenable) go_idle();
          else if (m_t + 1 == OFF) start_burst(m_bursts + 1);
          else m_t++;
        end
        default: if (!soundenable) go_idle();
      endcase
    end
  endtask

  task automatic step();
    logic exp_spk;
    @(posedge clk);
    model_edge();
    #1;
    exp_spk = (m_phase == P_TONE) && (((m_t / m_h) % 2) == 0);
    chk("speaker", speaker, exp_spk);
    chk("active", active, (m_phase == P_TONE || m_phase == P_GAP));
    chk("done", done, (m_phase == P_HOLD));
    chk("bursts", bursts, m_bursts);
  endtask

  initial begin
    m_phase = P_IDLE; m_t = 0; m_h = HB; m_bursts = 0;
    reset = 1'b1; soundenable = 1'b0; amount = 8'd0;
    step();
    step();
    chk("rst_speaker", speaker, 0);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_bursts", bursts, 0);
    reset = 1'b0;
    step();

    // Two full bursts then HOLD; pitch changes mid-burst 1.
    amount = 8'd1; soundenable = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      step();
      if (c == 5)  amount = 8'd3;
      if (c == 1)  chk("s1_hi_c1", speaker, 1);
      if (c == 6)  chk("s1_hi_c6", speaker, 1);
      if (c == 7)  chk("s1_lo_c7", speaker, 0);
      if (c == 13) chk("s1_hi_c13", speaker, 1);
      if (c == 20) chk("s1_lo_c20", speaker, 0);
      if (c == 21) begin chk("s1_gap_act", active, 1); chk("s1_gap_spk", speaker, 0); end
      if (c == 30) chk("s1_gap_c30", speaker, 0);
      if (c == 31) begin chk("s1_b2_cnt", bursts, 2); chk("s1_b2_spk", speaker, 1); end
      if (c == 40) chk("s1_b2_hi_c40", speaker, 1);
      if (c == 41) chk("s1_b2_lo_c41", speaker, 0);
      if (c == 51) begin chk("hold_done", done, 1); chk("hold_act", active, 0); chk("hold_spk", speaker, 0); end
    end
    soundenable = 1'b0;
    step();
    chk("hold_exit_bursts", bursts, 0);
    chk("hold_exit_done", done, 0);

    // Early disable during TONE, then restart.
    amount = 8'd0; soundenable = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 8) soundenable = 1'b0;
      if (c == 9) begin chk("dis_spk", speaker, 0); chk("dis_act", active, 0); end
    end
    soundenable = 1'b1;
    step();
    chk("reen_bursts", bursts, 1);
    chk("reen_spk", speaker, 1);
    soundenable = 1'b0;
    step();

    // Disable on the final TONE cycle wins over the move to GAP.
    soundenable = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      if (c == 20) soundenable = 1'b0;
      if (c == 21) begin chk("last_act", active, 0); chk("last_bursts", bursts, 0); end
    end

    // Reset in GAP while enable stays high.
    soundenable = 1'b1;
    for (int c = 1; c <= 25; c++) step();
    reset = 1'b1;
    step();
    chk("gaprst_act", active, 0);
    chk("gaprst_spk", speaker, 0);
    chk("gaprst_bursts", bursts, 0);
    reset = 1'b0;
    step();
    chk("gaprst_tone_spk", speaker, 1);
    chk("gaprst_tone_act", active, 1);

    // Randomized enable / pitch / reset traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) soundenable = ~soundenable;
      if ($urandom_range(0, 7) == 0)
        amount = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
